seq_pattern_gen: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 21 ++
 rtl/seq_gen_shreg.sv | 48 ++++
 rtl/seq_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generators.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a length field that can hold the values 0..width.
  function automatic int lw_for(input int width);
    return $clog2(width) + 1;
  endfunction

  // A length of 0, or one larger than the register, means "use the full width".
  function automatic int clamp_len(input int len, input int width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-shift register feeding the serial line.
// It holds the bits still to be driven *after* the one currently on DOUT,
// left-aligned, plus a count of how many such bits remain.
module seq_gen_shreg #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    len,
  output logic             msb,
  output logic             last
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LW-1:0]    cnt_q, cnt_d;

  // Load drops the first bit (driven directly by the caller); shift advances one bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = data << (WIDTH - int'(len) + 1);
      cnt_d = len - LW'(1);
    end else if (shift) begin
      sr_d  = sr_q << 1;
      cnt_d = (cnt_q != '0) ? cnt_q - LW'(1) : cnt_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb  = sr_q[WIDTH-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern generator: sends an up-to-WIDTH-bit pattern MSB-first,
// optionally repeated with fixed idle gaps between passes.
//
// Handshake: START is a request sampled only while BUSY=0 (IDLE or DONE) and
// ABORT=0; acceptance is implied by BUSY=1 in the following cycle, which also
// carries the first pattern bit. While BUSY=1 START is ignored.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int       WIDTH    = 8,
  parameter int       RPT_W    = 4,
  parameter int       GAP_CYC  = 2,
  parameter logic     IDLE_LVL = 1'b0,
  localparam int      LW       = lw_for(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [LW-1:0]    LEN,
  input  logic [RPT_W-1:0] REPEAT,
  output logic             DOUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             DONE,
  output state_e           dbg_state
);

  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  state_e           state_q, state_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [RPT_W-1:0] pass_q, pass_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;

  logic             sr_load, sr_shift, sr_msb, sr_last;
  logic [WIDTH-1:0] sr_data;
  logic [LW-1:0]    sr_len;
  logic [LW-1:0]    eff_len;
  logic [IW-1:0]    new_idx, cur_idx;

  assign eff_len = LW'(clamp_len(int'(LEN), WIDTH));
  assign new_idx = IW'(eff_len - LW'(1));
  assign cur_idx = IW'(len_q - LW'(1));

  seq_gen_shreg #(.WIDTH(WIDTH), .LW(LW)) u_shreg (
    .clk   (CLK),
    .rst   (RESET),
    .load  (sr_load),
    .shift (sr_shift),
    .data  (sr_data),
    .len   (sr_len),
    .msb   (sr_msb),
    .last  (sr_last)
  );

  // Next-state and registered-output logic; outputs default to the idle line.
  always_comb begin
    state_d  = state_q;
    dout_d   = IDLE_LVL;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    gap_d    = gap_q;
    pass_d   = pass_q;
    pat_d    = pat_q;
    len_d    = len_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_data  = pat_q;
    sr_len   = len_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (START && !ABORT) begin
          pat_d   = PATTERN;
          len_d   = eff_len;
          pass_d  = REPEAT;
          sr_load = 1'b1;
          sr_data = PATTERN;
          sr_len  = eff_len;
          dout_d  = PATTERN[new_idx];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (!sr_last) begin
          sr_shift = 1'b1;
          dout_d   = sr_msb;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end else if (pass_q != '0) begin
          pass_d = pass_q - RPT_W'(1);
          busy_d = 1'b1;
          if (GAP_CYC > 0) begin
            gap_d   = GAP_LAST;
            state_d = ST_GAP;
          end else begin
            // Zero gap: restart the pattern on the very next cycle.
            sr_load = 1'b1;
            dout_d  = pat_q[cur_idx];
            valid_d = 1'b1;
          end
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          sr_load = 1'b1;
          dout_d  = pat_q[cur_idx];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          gap_d  = gap_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      dout_q  <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      pass_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      pass_q  <= pass_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
    end
  end

  assign DOUT      = dout_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: each scenario is a per-cycle table of
// stimulus (START/ABORT/RESET) and hand-computed {DOUT,VALID,BUSY,DONE}.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  localparam int WIDTH = 8;
  localparam int RPT_W = 4;
  localparam int LW    = 4;

  // Clock and reset
  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic [WIDTH-1:0] PATTERN = '0;
  logic [LW-1:0]    LEN = '0;
  logic [RPT_W-1:0] REPEAT = '0;
  logic             DOUT, VALID, BUSY, DONE;
  state_e           dbg_state;

  always #5 CLK = ~CLK;

  seq_pattern_gen #(
    .WIDTH(WIDTH), .RPT_W(RPT_W), .GAP_CYC(2), .IDLE_LVL(1'b0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .PATTERN(PATTERN), .LEN(LEN), .REPEAT(REPEAT),
    .DOUT(DOUT), .VALID(VALID), .BUSY(BUSY), .DONE(DONE),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] det_sh;
  int         det_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Driver: cycle i checks outputs against table entry [n-1-i], then applies
  // that cycle's stimulus, which the DUT samples at the following edge.
  task automatic run(input string tag, input int n,
                     input logic [63:0] st, input logic [63:0] ab, input logic [63:0] rs,
                     input logic [63:0] d, input logic [63:0] v,
                     input logic [63:0] b, input logic [63:0] dn);
    logic [3:0] e;
    for (int i = 0; i < n; i++)
      exp_q.push_back({d[n-1-i], v[n-1-i], b[n-1-i], dn[n-1-i]});
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check_val($sformatf("%s[%0d]", tag, i), {28'd0, DOUT, VALID, BUSY, DONE}, {28'd0, e});
      det_sh = {det_sh[2:0], DOUT};
      if (det_sh == 4'b1011) det_cnt++;
      START = st[n-1-i];
      ABORT = ab[n-1-i];
      RESET = rs[n-1-i];
      tick();
    end
    START = 1'b0;
    ABORT = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic set_req(input logic [WIDTH-1:0] p, input logic [LW-1:0] l, input logic [RPT_W-1:0] r);
    PATTERN = p;
    LEN     = l;
    REPEAT  = r;
  endtask

  initial begin
    det_sh  = '0;
    det_cnt = 0;
    repeat (3) tick();
    check_val("rst_dout",  {31'd0, DOUT},  32'd0);
    check_val("rst_valid", {31'd0, VALID}, 32'd0);
    check_val("rst_busy",  {31'd0, BUSY},  32'd0);
    check_val("rst_done",  {31'd0, DONE},  32'd0);
    check_val("rst_state", {30'd0, dbg_state}, 32'd0);
    RESET = 1'b0;
    tick();

    // Single pass of 1011
    set_req(8'h0B, 4'd4, 4'd0);
    run("single", 7, 64'b1000000, 64'b0, 64'b0,
        64'b0101100, 64'b0111100, 64'b0111100, 64'b0000010);

    // Three passes with two-cycle gaps; a 1011 detector on DOUT fires three times
    det_sh  = '0;
    det_cnt = 0;
    set_req(8'h0B, 4'd4, 4'd2);
    run("repeat", 19, 64'b1000000000000000000, 64'b0, 64'b0,
        64'b0101100101100101100, 64'b0111100111100111100,
        64'b0111111111111111100, 64'b0000000000000000010);
    check_val("det_hits", det_cnt, 32'd3);

    // LEN=0 and LEN=9 both send all 8 bits
    set_req(8'hA5, 4'd0, 4'd0);
    run("len0", 11, 64'b10000000000, 64'b0, 64'b0,
        64'b01010010100, 64'b01111111100, 64'b01111111100, 64'b00000000010);
    set_req(8'hA5, 4'd9, 4'd0);
    run("len9", 11, 64'b10000000000, 64'b0, 64'b0,
        64'b01010010100, 64'b01111111100, 64'b01111111100, 64'b00000000010);

    // Abort after two bits (START alongside is ignored), then ABORT blocks START in IDLE
    set_req(8'hF0, 4'd8, 4'd0);
    run("abort", 8, 64'b10100100, 64'b00100100, 64'b0,
        64'b01100000, 64'b01100000, 64'b01100000, 64'b0);

    // Reset during the first gap of a four-pass run, then a clean transmission
    set_req(8'h0B, 4'd4, 4'd3);
    run("rst_gap", 7, 64'b1000000, 64'b0, 64'b0000010,
        64'b0101100, 64'b0111100, 64'b0111110, 64'b0);
    set_req(8'h0B, 4'd4, 4'd0);
    run("after_rst", 7, 64'b1000000, 64'b0, 64'b0,
        64'b0101100, 64'b0111100, 64'b0111100, 64'b0000010);

    // START held through DONE restarts immediately; a pulse while busy is ignored
    run("b2b", 12, 64'b111111010000, 64'b0, 64'b0,
        64'b010110101100, 64'b011110111100, 64'b011110111100, 64'b000001000010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
